led_pattern_sched: RTL and testbench

Sequencing controller for the `blink_led` array. It generates the per-LED `mask` vector that selects which LEDs blink, and it advances the pattern only after the currently tracked LED finishes a full on/off blink. Four patterns are supported: bounce, chase, fill and all-on. Pattern changes are queued and applied at the next step boundary. It sits between the button/mode logic and the `blink_led` instances: `mask_o` drives their `mask_i`, and their `led_o` outputs return on `led_i`.

---
 rtl/led_pattern_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_led_pattern_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sched.sv
// -----------------------------------------------------------------------------
// led_pattern_sched
//
// Sequencing controller for the blink_led array. It produces the per-LED mask
// that selects which LEDs blink. The pattern advances only after the tracked
// LED (led_i[ptr]) has completed a full on/off blink. Supported patterns are
// BOUNCE, CHASE, FILL and ALL. Mode changes requested while running are queued
// and applied at the next step boundary.
//
// Optional feature macro: LED_PATTERN_SCHED_WDOG_EN
//   defined   : a watchdog forces an advance (stall_o pulse) when the tracked
//               LED stays silent for TIMEOUT cycles.
//   undefined : no watchdog counter is built; stall_o is constant 0.
//
// Ports
//   clk_i       in   1          system clock
//   arst_i      in   1          asynchronous active-high reset
//   en_i        in   1          sequencer enable (low -> IDLE on next edge)
//   pause_i     in   1          freeze state, mask, pointer and watchdog
//   mode_i      in   2          requested pattern (0 BOUNCE,1 CHASE,2 FILL,3 ALL)
//   mode_load_i in   1          strobe that queues mode_i
//   led_i       in   LED_WIDTH  blink outputs returned from blink_led array
//   mask_o      out  LED_WIDTH  registered mask to blink_led array
//   mode_o      out  2          pattern currently running
//   step_o      out  1          pulse on every pattern advance
//   done_o      out  1          pulse when the pattern completes a cycle
//   stall_o     out  1          pulse on a watchdog-forced advance
// -----------------------------------------------------------------------------
module led_pattern_sched #(
    parameter int LED_WIDTH = 8,
    parameter int TIMEOUT   = 50_000_000
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 en_i,
    input  logic                 pause_i,
    input  logic [1:0]           mode_i,
    input  logic                 mode_load_i,
    input  logic [LED_WIDTH-1:0] led_i,
    output logic [LED_WIDTH-1:0] mask_o,
    output logic [1:0]           mode_o,
    output logic                 step_o,
    output logic                 done_o,
    output logic                 stall_o
);

    localparam int                 LED_PTR = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
    localparam logic [LED_PTR-1:0] PTR_MAX = LED_PTR'(LED_WIDTH - 1);

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_ALL    = 2'd3;

    if (LED_WIDTH < 2) begin : g_bad_width
        $error("led_pattern_sched: LED_WIDTH must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("led_pattern_sched: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ON  = 2'd1,
        S_WAIT_OFF = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LED_WIDTH-1:0] mask_d;
    logic [1:0]           mode_d;
    logic [1:0]           pend_mode_q, pend_mode_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [LED_PTR-1:0]   ptr_q, ptr_d;
    logic                 dir_down_q, dir_down_d;
    logic                 step_d, done_d, stall_d;
    logic                 do_adv;
    logic                 wd_expired;

    // Result of a normal (non-mode-switch) advance for the running pattern.
    logic [LED_WIDTH-1:0] adv_mask;
    logic [LED_PTR-1:0]   adv_ptr;
    logic                 adv_dir_down;
    logic                 adv_done;

    function automatic logic [LED_WIDTH-1:0] init_mask(input logic [1:0] mode);
        return (mode == MODE_ALL) ? '1 : LED_WIDTH'(1);
    endfunction

    // Thermometer code with bits 0..top set.
    function automatic logic [LED_WIDTH-1:0] thermo_mask(input logic [LED_PTR-1:0] top);
        logic [LED_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < LED_WIDTH; i++) begin
            m[i] = (i <= int'(top));
        end
        return m;
    endfunction

    always_comb begin
        adv_mask     = '0;
        adv_ptr      = ptr_q;
        adv_dir_down = dir_down_q;
        adv_done     = 1'b0;
        case (mode_o)
            MODE_BOUNCE: begin
                adv_ptr = dir_down_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
                // Direction reverses on arrival at either end so the next
                // advance already heads back.
                if (adv_ptr == PTR_MAX) begin
                    adv_dir_down = 1'b1;
                end else if (adv_ptr == '0) begin
                    adv_dir_down = 1'b0;
                end
                adv_mask = LED_WIDTH'(1) << adv_ptr;
                adv_done = (adv_ptr == '0);
            end
            MODE_CHASE: begin
                if (ptr_q == PTR_MAX) begin
                    adv_ptr  = '0;
                    adv_done = 1'b1;
                end else begin
                    adv_ptr = ptr_q + 1'b1;
                end
                adv_mask = LED_WIDTH'(1) << adv_ptr;
            end
            MODE_FILL: begin
                if (ptr_q == PTR_MAX) begin
                    adv_ptr  = '0;
                    adv_done = 1'b1;
                end else begin
                    adv_ptr = ptr_q + 1'b1;
                end
                adv_mask = thermo_mask(adv_ptr);
            end
            default: begin
                adv_ptr      = '0;
                adv_dir_down = 1'b0;
                adv_mask     = '1;
                adv_done     = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_o;
        mode_d      = mode_o;
        pend_mode_d = pend_mode_q;
        pend_vld_d  = pend_vld_q;
        ptr_d       = ptr_q;
        dir_down_d  = dir_down_q;
        step_d      = 1'b0;
        done_d      = 1'b0;
        stall_d     = 1'b0;
        do_adv      = 1'b0;

        if (!en_i) begin
            // Disable wins over pause; mode_o is kept for the next enable.
            if (state_q == S_IDLE && mode_load_i) begin
                mode_d = mode_i;
            end
            state_d    = S_IDLE;
            mask_d     = '0;
            pend_vld_d = 1'b0;
            ptr_d      = '0;
            dir_down_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            // Nothing is running, so a strobe takes effect immediately and
            // also selects the initial mask if we start this cycle.
            if (mode_load_i) begin
                mode_d = mode_i;
            end
            if (!pause_i) begin
                state_d    = S_WAIT_ON;
                mask_d     = init_mask(mode_d);
                ptr_d      = '0;
                dir_down_d = 1'b0;
            end
        end else begin
            if (mode_load_i) begin
                pend_mode_d = mode_i;
                pend_vld_d  = 1'b1;
            end
            if (!pause_i) begin
                if (state_q == S_WAIT_ON) begin
                    if (led_i[ptr_q]) begin
                        state_d = S_WAIT_OFF;
                    end else if (wd_expired) begin
                        do_adv  = 1'b1;
                        stall_d = 1'b1;
                    end
                end else begin
                    if (!led_i[ptr_q]) begin
                        do_adv = 1'b1;
                    end else if (wd_expired) begin
                        do_adv  = 1'b1;
                        stall_d = 1'b1;
                    end
                end
            end
            if (do_adv) begin
                state_d = S_WAIT_ON;
                step_d  = 1'b1;
                // Using the _d copies lets a strobe in this same cycle win.
                if (pend_vld_d) begin
                    mode_d     = pend_mode_d;
                    mask_d     = init_mask(pend_mode_d);
                    ptr_d      = '0;
                    dir_down_d = 1'b0;
                    pend_vld_d = 1'b0;
                end else begin
                    mask_d     = adv_mask;
                    ptr_d      = adv_ptr;
                    dir_down_d = adv_dir_down;
                    done_d     = adv_done;
                end
            end
        end
    end

`ifdef LED_PATTERN_SCHED_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q;

    assign wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT));

    // Restarts on any state change, including a forced advance that stays
    // in WAIT_ON; holds while paused.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wd_cnt_q <= '0;
        end else if (!en_i || state_q == S_IDLE || state_d != state_q || stall_d) begin
            wd_cnt_q <= '0;
        end else if (!pause_i) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= S_IDLE;
            mask_o      <= '0;
            mode_o      <= MODE_BOUNCE;
            pend_mode_q <= MODE_BOUNCE;
            pend_vld_q  <= 1'b0;
            ptr_q       <= '0;
            dir_down_q  <= 1'b0;
            step_o      <= 1'b0;
            done_o      <= 1'b0;
            stall_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_o      <= mask_d;
            mode_o      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_vld_q  <= pend_vld_d;
            ptr_q       <= ptr_d;
            dir_down_q  <= dir_down_d;
            step_o      <= step_d;
            done_o      <= done_d;
            stall_o     <= stall_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
module tb_led_pattern_sched;

    localparam int LW      = 4;
    localparam int TMO     = 16;
`ifdef LED_PATTERN_SCHED_WDOG_EN
    localparam bit WD_ON   = 1'b1;
`else
    localparam bit WD_ON   = 1'b0;
`endif
    localparam int PH_IDLE = 0;
    localparam int PH_ON   = 1;
    localparam int PH_OFF  = 2;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          pause_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic          mode_load_i = 1'b0;
    logic [LW-1:0] led_i = '0;
    logic [LW-1:0] mask_o;
    logic [1:0]    mode_o;
    logic          step_o;
    logic          done_o;
    logic          stall_o;

    int tests = 0;
    int fails = 0;

    // Reference model state: pattern position rather than RTL registers.
    int            m_phase = PH_IDLE;
    logic [1:0]    m_mode  = 2'd0;
    int            m_pos   = 0;
    bit            m_pend  = 1'b0;
    logic [1:0]    m_pmode = 2'd0;
    int            m_wd    = 0;
    logic [LW-1:0] m_mask  = '0;
    bit            m_step  = 1'b0;
    bit            m_done  = 1'b0;
    bit            m_stall = 1'b0;

    led_pattern_sched #(.LED_WIDTH(LW), .TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .en_i        (en_i),
        .pause_i     (pause_i),
        .mode_i      (mode_i),
        .mode_load_i (mode_load_i),
        .led_i       (led_i),
        .mask_o      (mask_o),
        .mode_o      (mode_o),
        .step_o      (step_o),
        .done_o      (done_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Length of one full pattern cycle, in steps.
    function automatic int pat_len(input logic [1:0] mode);
        case (mode)
            2'd0:    return 2 * LW - 2;
            2'd1:    return LW;
            2'd2:    return LW;
            default: return 1;
        endcase
    endfunction

    // LED whose blink gates the next step at a given pattern position.
    function automatic int pat_led(input logic [1:0] mode, input int pos);
        case (mode)
            2'd0:    return (pos < LW) ? pos : (2 * LW - 2 - pos);
            2'd1:    return pos;
            2'd2:    return pos;
            default: return 0;
        endcase
    endfunction

    function automatic logic [LW-1:0] pat_mask(input logic [1:0] mode, input int pos);
        logic [LW-1:0] one;
        one = 1;
        case (mode)
            2'd2:    return (one << (pos + 1)) - one;
            2'd3:    return '1;
            default: return one << pat_led(mode, pos);
        endcase
    endfunction

    function automatic int onehot_idx(input logic [LW-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < LW; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_edge();
        int tr;
        bit adv;
        adv = 1'b0;
        m_step = 1'b0; m_done = 1'b0; m_stall = 1'b0;
        if (!en_i) begin
            if (m_phase == PH_IDLE && mode_load_i) m_mode = mode_i;
            m_phase = PH_IDLE; m_mask = '0; m_pend = 1'b0; m_pos = 0; m_wd = 0;
        end else if (m_phase == PH_IDLE) begin
            if (mode_load_i) m_mode = mode_i;
            if (!pause_i) begin
                m_phase = PH_ON; m_pos = 0; m_mask = pat_mask(m_mode, 0); m_wd = 0;
            end
        end else begin
            if (mode_load_i) begin
                m_pend = 1'b1; m_pmode = mode_i;
            end
            if (!pause_i) begin
                tr = pat_led(m_mode, m_pos);
                if (m_phase == PH_ON && led_i[tr]) begin
                    m_phase = PH_OFF; m_wd = 0;
                end else if (m_phase == PH_OFF && !led_i[tr]) begin
                    adv = 1'b1;
                end else if (WD_ON && m_wd == TMO) begin
                    adv = 1'b1; m_stall = 1'b1;
                end else begin
                    m_wd++;
                end
                if (adv) begin
                    m_step = 1'b1;
                    if (m_pend) begin
                        m_mode = m_pmode; m_pos = 0; m_pend = 1'b0;
                    end else begin
                        m_pos = (m_pos + 1) % pat_len(m_mode);
                        m_done = (m_pos == 0);
                    end
                    m_mask = pat_mask(m_mode, m_pos);
                    m_phase = PH_ON; m_wd = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mask"},  32'(mask_o),  32'(m_mask));
        check({tag, ".mode"},  32'(mode_o),  32'(m_mode));
        check({tag, ".step"},  32'(step_o),  32'(m_step));
        check({tag, ".done"},  32'(done_o),  32'(m_done));
        check({tag, ".stall"}, 32'(stall_o), 32'(m_stall));
    endtask

    task automatic tick(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        check_all(tag);
        mode_load_i = 1'b0;
    endtask

    // One full on/off blink of the tracked LED; returns the outputs after it.
    task automatic blink_step(input string tag, output logic [LW-1:0] mk,
                              output logic st, output logic dn);
        led_i = '0;
        led_i[pat_led(m_mode, m_pos)] = 1'b1;
        tick(tag);
        led_i = '0;
        tick(tag);
        mk = mask_o; st = step_o; dn = done_o;
    endtask

    logic [LW-1:0] mk;
    logic          st, dn;
    int            n_step, n_done, n_pulse, n_wait, idx;
    logic [LW-1:0] exp_chase [5];
    int            exp_bounce [6];

    initial begin
        exp_chase  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bounce = '{1, 2, 3, 2, 1, 0};

        // Reset state
        #12;
        check("rst.mask",  32'(mask_o),  32'h0);
        check("rst.mode",  32'(mode_o),  32'h0);
        check("rst.step",  32'(step_o),  32'h0);
        check("rst.done",  32'(done_o),  32'h0);
        check("rst.stall", 32'(stall_o), 32'h0);
        arst_i = 1'b0;
        @(posedge clk_i); #1;

        // CHASE: strobe in IDLE sets mode directly, then enable
        mode_i = 2'd1; mode_load_i = 1'b1;
        tick("chase.load");
        check("chase.mode_idle", 32'(mode_o), 32'd1);
        en_i = 1'b1;
        tick("chase.en");
        check("chase.m0", 32'(mask_o), 32'(exp_chase[0]));
        n_done = 0;
        for (int i = 1; i < 5; i++) begin
            blink_step("chase", mk, st, dn);
            check("chase.seq", 32'(mk), 32'(exp_chase[i]));
            check("chase.step", 32'(st), 32'd1);
            if (dn) n_done++;
        end
        check("chase.done_cnt", 32'(n_done), 32'd1);
        check("chase.done_last", 32'(dn), 32'd1);

        // BOUNCE: 0,1,2,3,2,1,0
        en_i = 1'b0;
        tick("bounce.dis");
        mode_i = 2'd0; mode_load_i = 1'b1;
        tick("bounce.load");
        en_i = 1'b1;
        tick("bounce.en");
        check("bounce.i0", 32'(onehot_idx(mask_o)), 32'd0);
        n_step = 0; n_done = 0;
        for (int i = 0; i < 6; i++) begin
            blink_step("bounce", mk, st, dn);
            idx = onehot_idx(mk);
            check("bounce.idx", 32'(idx), 32'(exp_bounce[i]));
            if (st) n_step++;
            if (dn) n_done++;
        end
        check("bounce.steps", 32'(n_step), 32'd6);
        check("bounce.done_cnt", 32'(n_done), 32'd1);
        check("bounce.done_last", 32'(dn), 32'd1);

        // FILL with queued switch to ALL during WAIT_ON at mask 0011
        en_i = 1'b0;
        tick("fill.dis");
        mode_i = 2'd2; mode_load_i = 1'b1;
        tick("fill.load");
        en_i = 1'b1;
        tick("fill.en");
        blink_step("fill", mk, st, dn);
        check("fill.m1", 32'(mk), 32'b0011);
        mode_i = 2'd3; mode_load_i = 1'b1;
        tick("fill.strobe");
        check("fill.hold_mode", 32'(mode_o), 32'd2);
        blink_step("fill.sw", mk, st, dn);
        check("fill.sw_mask", 32'(mk), 32'b1111);
        check("fill.sw_mode", 32'(mode_o), 32'd3);
        check("fill.sw_step", 32'(st), 32'd1);
        check("fill.sw_done", 32'(dn), 32'd0);

        // Switch to CHASE via the queue, then pause in WAIT_OFF
        mode_i = 2'd1; mode_load_i = 1'b1;
        tick("pause.strobe");
        blink_step("pause.sw", mk, st, dn);
        check("pause.sw_mask", 32'(mk), 32'b0001);
        blink_step("pause.pre", mk, st, dn);
        check("pause.pre_mask", 32'(mk), 32'b0010);
        led_i = 4'b0010;
        tick("pause.off");
        pause_i = 1'b1;
        n_pulse = 0;
        for (int i = 0; i < 100; i++) begin
            led_i = LW'($urandom);
            tick("pause");
            if (step_o || done_o || stall_o || mask_o !== 4'b0010) n_pulse++;
        end
        check("pause.frozen", 32'(n_pulse), 32'd0);
        led_i = '0;
        tick("pause.rel_hold");
        pause_i = 1'b0;
        tick("pause.resume");
        check("pause.resume_mask", 32'(mask_o), 32'b0100);
        check("pause.resume_step", 32'(step_o), 32'd1);

        // Disable in WAIT_OFF, then asynchronous reset mid-cycle
        led_i = 4'b0100;
        tick("dis.off");
        en_i = 1'b0;
        tick("dis");
        check("dis.mask", 32'(mask_o), 32'h0);
        check("dis.mode_kept", 32'(mode_o), 32'd1);
        en_i = 1'b1; led_i = '0;
        tick("arst.en");
        led_i = 4'b0001;
        tick("arst.off");
        #1 arst_i = 1'b1;
        #1;
        check("arst.mask",  32'(mask_o),  32'h0);
        check("arst.mode",  32'(mode_o),  32'h0);
        check("arst.step",  32'(step_o),  32'h0);
        check("arst.done",  32'(done_o),  32'h0);
        check("arst.stall", 32'(stall_o), 32'h0);
        m_phase = PH_IDLE; m_mode = 2'd0; m_pos = 0; m_pend = 1'b0; m_wd = 0;
        m_mask = '0; m_step = 1'b0; m_done = 1'b0; m_stall = 1'b0;
        #1 arst_i = 1'b0;

        // Silent tracked LED: watchdog forces an advance, or the block waits
        led_i = '0;
        tick("wd.en");
        n_wait = 0;
        for (int i = 0; i < 40; i++) begin
            tick("wd");
            n_wait++;
            if (stall_o) break;
        end
        if (WD_ON) begin
            check("wd.latency", 32'(n_wait), 32'(TMO + 1));
            check("wd.stall", 32'(stall_o), 32'd1);
            check("wd.step", 32'(step_o), 32'd1);
            check("wd.mask", 32'(mask_o), 32'b0010);
        end else begin
            check("wd.no_stall", 32'(stall_o), 32'd0);
            check("wd.held_mask", 32'(mask_o), 32'b0001);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            en_i        = ($urandom_range(0, 49) != 0);
            pause_i     = ($urandom_range(0, 7) == 0);
            mode_load_i = ($urandom_range(0, 11) == 0);
            mode_i      = 2'($urandom);
            led_i       = LW'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
